rload_trim_cal_ctrl: RTL and testbench

Digital calibration sequencer for the DAC differential resistor load. It drives a binary-weighted trim code for the load resistance and injects a known reference current through cal_force. It runs a successive-approximation (SAR) search on a comparator decision until vout matches the target voltage. It sits beside the load in the DAC output stage, runs at power-up or on demand, and holds the final code for mission mode.

---
 rtl/rload_cal_pkg.sv | 18 +
 rtl/rload_cal_settle_cnt.sv | 32 +++
 rtl/rload_trim_cal_ctrl.sv | 147 ++++++++++++++
 tb/tb_rload_trim_cal_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/rload_cal_pkg.sv
// Shared types and helpers for the resistor-load trim calibration sequencer.
package rload_cal_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE,
    ERROR
  } rload_cal_state_t;

  localparam int DEF_TRIM_W = 6;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rload_cal_settle_cnt.sv
// Settle-time counter: holds at zero while cleared, counts while enabled.
// tc flags SETTLE_CYC counted cycles, tc_long one cycle more.
// No flow control; the sequencer reads the flags combinationally.
module rload_cal_settle_cnt #(
  parameter int SETTLE_CYC = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc,
  output logic tc_long
);

  localparam int CW = $clog2(SETTLE_CYC + 1) + 1;

  logic [CW-1:0] cnt;

  assign tc      = (cnt == CW'(SETTLE_CYC - 1));
  assign tc_long = (cnt == CW'(SETTLE_CYC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc_long) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rload_trim_cal_ctrl.sv
// SAR calibration sequencer for the DAC resistor-load trim code; RLOAD_CAL_AVG_EN enables 3-sample majority decisions.
// cal_done rises TRIM_W*(SETTLE_CYC+1)+1 edges after cal_start (TRIM_W*(SETTLE_CYC+3)+1 with averaging).
// No backpressure: cal_start/trim_wr while busy are dropped; vssana_ok loss aborts to ERROR.
module rload_trim_cal_ctrl
  import rload_cal_pkg::*;
#(
  parameter int TRIM_W       = DEF_TRIM_W,
  parameter int SETTLE_CYC   = 8,
  parameter int TRIM_DEFAULT = 1 << (TRIM_W - 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cal_start,
  input  logic              comp_out,
  input  logic              vssana_ok,
  input  logic              trim_wr,
  input  logic [TRIM_W-1:0] trim_wdata,
  output logic [TRIM_W-1:0] trim_code,
  output logic              cal_force,
  output logic              cal_busy,
  output logic              cal_done,
  output logic              cal_err
);

  localparam int                IDX_W    = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
  localparam logic [TRIM_W-1:0] DEF_CODE = TRIM_W'(TRIM_DEFAULT);
  localparam logic [TRIM_W-1:0] MID_CODE = TRIM_W'(1 << (TRIM_W - 1));
  localparam logic [IDX_W-1:0]  TOP_IDX  = IDX_W'(TRIM_W - 1);

  rload_cal_state_t state;
  logic [IDX_W-1:0] idx;
  logic             first_bit;
  logic             settle_tc;
  logic             settle_tc_long;
  logic             settle_end;
  logic             sample_end;
  logic             bit_high;
  logic             abort;

  rload_cal_settle_cnt #(
    .SETTLE_CYC(SETTLE_CYC)
  ) u_settle_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (state != SETTLE),
    .en     (state == SETTLE),
    .tc     (settle_tc),
    .tc_long(settle_tc_long)
  );

  // The first settle also covers reference-current turn-on, so it runs one cycle longer.
  assign settle_end = first_bit ? settle_tc_long : settle_tc;
  assign abort      = cal_busy && !vssana_ok;

`ifdef RLOAD_CAL_AVG_EN
  logic [1:0] samp_cnt;
  logic [1:0] samp_hist;

  assign sample_end = (samp_cnt == 2'd2);
  assign bit_high   = maj3(samp_hist[0], samp_hist[1], comp_out);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_cnt  <= '0;
      samp_hist <= '0;
    end else if (state == SAMPLE && !sample_end) begin
      samp_hist[samp_cnt[0]] <= comp_out;
      samp_cnt               <= samp_cnt + 1'b1;
    end else begin
      samp_cnt <= '0;
    end
  end
`else
  assign sample_end = 1'b1;
  assign bit_high   = comp_out;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= TOP_IDX;
      first_bit <= 1'b0;
      trim_code <= DEF_CODE;
      cal_force <= 1'b0;
      cal_busy  <= 1'b0;
      cal_done  <= 1'b0;
      cal_err   <= 1'b0;
    end else if (abort) begin
      state     <= ERROR;
      trim_code <= DEF_CODE;
      cal_force <= 1'b0;
      cal_busy  <= 1'b0;
      cal_done  <= 1'b0;
      cal_err   <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (cal_start) begin
            cal_done <= 1'b0;
            if (vssana_ok) begin
              state     <= SETTLE;
              idx       <= TOP_IDX;
              first_bit <= 1'b1;
              trim_code <= MID_CODE;
              cal_force <= 1'b1;
              cal_busy  <= 1'b1;
              cal_err   <= 1'b0;
            end else begin
              state     <= ERROR;
              trim_code <= DEF_CODE;
              cal_err   <= 1'b1;
            end
          end else if (trim_wr) begin
            trim_code <= trim_wdata;
          end
        end
        SETTLE: begin
          if (settle_end) begin
            state     <= SAMPLE;
            first_bit <= 1'b0;
          end
        end
        SAMPLE: begin
          if (sample_end) begin
            if (bit_high) begin
              trim_code[idx] <= 1'b0;
            end
            if (idx != '0) begin
              trim_code[idx - 1'b1] <= 1'b1;
              idx                   <= idx - 1'b1;
              state                 <= SETTLE;
            end else begin
              state     <= DONE;
              cal_force <= 1'b0;
              cal_busy  <= 1'b0;
              cal_done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rload_trim_cal_ctrl.sv
// Directed/randomized bench for rload_trim_cal_ctrl with a threshold comparator model.
module tb_rload_trim_cal_ctrl;

  localparam int TW   = 6;
  localparam int SC   = 8;
  localparam int MAXC = (1 << TW) - 1;
  localparam int MID  = 1 << (TW - 1);
`ifdef RLOAD_CAL_AVG_EN
  localparam int LAT      = TW * (SC + 3) + 1;
  localparam int ABORT_AT = 25;
`else
  localparam int LAT      = TW * (SC + 1) + 1;
  localparam int ABORT_AT = 21;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cal_start;
  logic          comp_out;
  logic          vssana_ok;
  logic          trim_wr;
  logic [TW-1:0] trim_wdata;
  logic [TW-1:0] trim_code;
  logic          cal_force;
  logic          cal_busy;
  logic          cal_done;
  logic          cal_err;

  int   thr = 37;
  int   ph  = 0;
  logic noise;
  int   errs = 0;
  int   tot  = 0;

  rload_trim_cal_ctrl #(
    .TRIM_W      (TW),
    .SETTLE_CYC  (SC),
    .TRIM_DEFAULT(MID)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cal_start (cal_start),
    .comp_out  (comp_out),
    .vssana_ok (vssana_ok),
    .trim_wr   (trim_wr),
    .trim_wdata(trim_wdata),
    .trim_code (trim_code),
    .cal_force (cal_force),
    .cal_busy  (cal_busy),
    .cal_done  (cal_done),
    .cal_err   (cal_err)
  );

  always #5 clk = ~clk;

  // Noise flips exactly one comparator decision in every three consecutive cycles.
  always @(posedge clk) ph <= (ph + 1) % 3;
`ifdef RLOAD_CAL_AVG_EN
  always_comb noise = (ph == 0);
`else
  always_comb noise = 1'b0;
`endif
  always_comb comp_out = (int'(trim_code) > thr) ^ noise;

  // A SAR search against "code > t" settles on the largest code not above t.
  function automatic int expect_code(input int t);
    if (t < 0) return 0;
    if (t > MAXC) return MAXC;
    return t;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
  endtask

  task automatic run_cal(input int t, input bit poke, output int lat);
    int n;
    bit held;
    thr  = t;
    held = 1'b1;
    pulse_start();
    n = 0;
    while (!cal_done && n < 200) begin
      if (cal_busy !== 1'b1 || cal_force !== 1'b1) held = 1'b0;
      if (poke && (n == 10 || n == 30)) begin
        cal_start  = 1'b1;
        trim_wr    = 1'b1;
        trim_wdata = TW'(5);
      end
      @(negedge clk);
      n++;
      cal_start = 1'b0;
      trim_wr   = 1'b0;
    end
    lat = n;
    check("force_busy_held", 32'(held), 32'd1);
  endtask

  initial begin
    int lat;
    int t;
    logic [TW-1:0] d;
    rst        = 1'b1;
    cal_start  = 1'b0;
    vssana_ok  = 1'b1;
    trim_wr    = 1'b0;
    trim_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_trim", 32'(trim_code), 32'(MID));
    check("rst_force", 32'(cal_force), 32'd0);
    check("rst_busy", 32'(cal_busy), 32'd0);
    check("rst_done", 32'(cal_done), 32'd0);
    check("rst_err", 32'(cal_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Refused start: ground rail out of bounds
    vssana_ok = 1'b0;
    @(negedge clk);
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    check("refuse_err", 32'(cal_err), 32'd1);
    check("refuse_force", 32'(cal_force), 32'd0);
    check("refuse_busy", 32'(cal_busy), 32'd0);
    check("refuse_trim", 32'(trim_code), 32'(MID));
    vssana_ok = 1'b1;

    // Manual write while idle in ERROR
    d = TW'($urandom_range(0, MAXC));
    trim_wr    = 1'b1;
    trim_wdata = d;
    @(negedge clk);
    trim_wr = 1'b0;
    check("wr_err_trim", 32'(trim_code), 32'(d));
    check("wr_err_keep", 32'(cal_err), 32'd1);

    // Nominal run with ignored start/write pokes while busy
    run_cal(37, 1'b1, lat);
    check("nom_lat", 32'(lat), 32'(LAT));
    check("nom_trim", 32'(trim_code), 32'(expect_code(37)));
    check("nom_done", 32'(cal_done), 32'd1);
    check("nom_err", 32'(cal_err), 32'd0);
    check("nom_force_off", 32'(cal_force), 32'd0);
    check("nom_busy_off", 32'(cal_busy), 32'd0);

    trim_wr    = 1'b1;
    trim_wdata = TW'(5);
    @(negedge clk);
    trim_wr = 1'b0;
    check("wr_done_trim", 32'(trim_code), 32'd5);
    check("wr_done_keep", 32'(cal_done), 32'd1);

    // Comparator stuck high / stuck low
    run_cal(-1, 1'b0, lat);
    check("all1_trim", 32'(trim_code), 32'(expect_code(-1)));
    check("all1_flags", {cal_done, cal_err}, 32'b10);
    run_cal(MAXC, 1'b0, lat);
    check("all0_trim", 32'(trim_code), 32'(expect_code(MAXC)));
    check("all0_flags", {cal_done, cal_err}, 32'b10);

    // Random targets
    for (int i = 0; i < 4; i++) begin
      t = int'($urandom_range(0, MAXC));
      run_cal(t, 1'b0, lat);
      check("rnd_trim", 32'(trim_code), 32'(expect_code(t)));
      check("rnd_lat", 32'(lat), 32'(LAT));
    end

    // Abort during the third settle window
    thr = 37;
    pulse_start();
    repeat (ABORT_AT) @(negedge clk);
    check("abort_pre_busy", 32'(cal_busy), 32'd1);
    vssana_ok = 1'b0;
    @(negedge clk);
    check("abort_trim", 32'(trim_code), 32'(MID));
    check("abort_err", 32'(cal_err), 32'd1);
    check("abort_busy", 32'(cal_busy), 32'd0);
    check("abort_force", 32'(cal_force), 32'd0);
    check("abort_done", 32'(cal_done), 32'd0);
    vssana_ok = 1'b1;
    t = int'($urandom_range(0, MAXC));
    run_cal(t, 1'b0, lat);
    check("recover_trim", 32'(trim_code), 32'(expect_code(t)));
    check("recover_flags", {cal_done, cal_err}, 32'b10);

    // Asynchronous reset in the middle of a settle window
    pulse_start();
    repeat (3) @(negedge clk);
    check("mid_busy", 32'(cal_busy), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_trim", 32'(trim_code), 32'(MID));
    check("arst_flags", {cal_force, cal_busy, cal_done, cal_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, tot);
    $finish;
  end

endmodule
